// File: rtl/io_ram_pkg.sv
// Shared types and constants for the I/O RAM arbiter slice.
//   IO_AW / IO_DW : address and data width of the 4096x8 I/O RAM port
//   req_e         : requester identity, also the bit index in grant vectors
//   owner_e       : owner of the previous cycle's grant, including "nobody"
package io_ram_pkg;

  localparam int IO_AW = 12;
  localparam int IO_DW = 8;

  typedef enum logic {
    REQ_H = 1'b0,
    REQ_E = 1'b1
  } req_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_H    = 2'b01,
    OWN_E    = 2'b10
  } owner_e;

  function automatic owner_e owner_of(req_e r);
    return (r == REQ_E) ? OWN_E : OWN_H;
  endfunction

  function automatic req_e other_of(req_e r);
    return (r == REQ_E) ? REQ_H : REQ_E;
  endfunction

endpackage

// File: rtl/io_ram_arb_if.sv
// One requester's access port onto the shared I/O RAM.
//   master : requester side (drives req/we/addr/wdata/lock)
//   slave  : arbiter side (drives gnt/rvalid/rdata)
// req is held until gnt; gnt is combinational in the request cycle;
// rvalid/rdata return read data one cycle after a read grant.
interface io_ram_arb_if
  import io_ram_pkg::*;
#(
  parameter int AW = IO_AW,
  parameter int DW = IO_DW
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          lock;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/io_ram_arb_rr_arb2.sv
// Two-way round-robin arbiter with a bounded lock.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : requests, indexed by req_e (0 = host, 1 = engine)
//   lock[1:0]  : requester asks to keep the grant next cycle
//   gnt[1:0]   : one-hot (or zero) grant, combinational, forced 0 in reset
// A locked owner keeps winning a contest only while burst_cnt < MAX_BURST,
// so a waiting requester is served within MAX_BURST+1 cycles.
module rr_arb2
  import io_ram_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  req_e       ptr;
  owner_e     owner;
  logic       owner_lock;
  logic [3:0] burst_cnt;

  req_e       winner;
  logic       any_req;
  logic       lock_open;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the if/else chain can leave a latch behind.
    winner    = ptr;
    gnt       = 2'b00;
    any_req   = req[0] | req[1];
    lock_open = owner_lock && (owner != OWN_NONE) &&
                (int'(burst_cnt) < MAX_BURST);

    if (req == 2'b01)      winner = REQ_H;
    else if (req == 2'b10) winner = REQ_E;
    else if (lock_open)    winner = (owner == OWN_E) ? REQ_E : REQ_H;

    if (rst_n && any_req) gnt = (winner == REQ_E) ? 2'b10 : 2'b01;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= REQ_H;
      owner      <= OWN_NONE;
      owner_lock <= 1'b0;
      burst_cnt  <= 4'd0;
    end else if (any_req) begin
      ptr        <= other_of(winner);
      owner      <= owner_of(winner);
      owner_lock <= (winner == REQ_E) ? lock[1] : lock[0];
      if (owner == owner_of(winner)) begin
        if (int'(burst_cnt) < MAX_BURST) burst_cnt <= burst_cnt + 4'd1;
      end else begin
        burst_cnt <= 4'd1;
      end
    end else begin
      owner      <= OWN_NONE;
      owner_lock <= 1'b0;
      burst_cnt  <= 4'd0;
    end
  end

endmodule

// File: rtl/io_ram_arb.sv
// Shares one port of the 4096x8 dual-port I/O RAM between the host loader
// (h) and the LZW engine (e).
//   clk, rst_n  : clock, asynchronous active-low reset
//   h, e        : requester ports (io_ram_arb_if.slave)
//   ram_en/wr   : RAM port enable / write enable
//   ram_addr    : RAM address, holds the last winner's value when idle
//   ram_wdata   : RAM write data, holds the last winner's value when idle
//   ram_rdata   : RAM read data, valid the cycle after a read enable
// Read data returns to the requester that won the read one cycle later.
module io_ram_arb
  import io_ram_pkg::*;
#(
  parameter int AW        = IO_AW,
  parameter int DW        = IO_DW,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  io_ram_arb_if.slave   h,
  io_ram_arb_if.slave   e,
  output logic          ram_en,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  logic [1:0]    gnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          h_rvalid_q, e_rvalid_q;
  logic [DW-1:0] h_rdata_q, e_rdata_q;

  rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({e.req, h.req}),
    .lock ({e.lock, h.lock}),
    .gnt  (gnt)
  );

  assign h.gnt  = gnt[0];
  assign e.gnt  = gnt[1];
  assign ram_en = |gnt;

  always_comb begin
    ram_wr    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if (gnt[0]) begin
      ram_wr    = h.we;
      ram_addr  = h.addr;
      ram_wdata = h.wdata;
    end else if (gnt[1]) begin
      ram_wr    = e.we;
      ram_addr  = e.addr;
      ram_wdata = e.wdata;
    end
  end

  // NOTE: only the small hold registers are reset; the RAM array itself lives
  // outside and is never cleared, so reset costs nothing per location.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      h_rvalid_q <= 1'b0;
      e_rvalid_q <= 1'b0;
      h_rdata_q  <= '0;
      e_rdata_q  <= '0;
    end else begin
      if (ram_en) begin
        addr_q  <= ram_addr;
        wdata_q <= ram_wdata;
      end
      h_rvalid_q <= gnt[0] & ~h.we;
      e_rvalid_q <= gnt[1] & ~e.we;
      if (h_rvalid_q) h_rdata_q <= ram_rdata;
      if (e_rvalid_q) e_rdata_q <= ram_rdata;
    end
  end

  // Data passes straight through in its valid cycle and is held afterwards.
  assign h.rvalid = h_rvalid_q;
  assign e.rvalid = e_rvalid_q;
  assign h.rdata  = h_rvalid_q ? ram_rdata : h_rdata_q;
  assign e.rdata  = e_rvalid_q ? ram_rdata : e_rdata_q;

endmodule

// File: tb/tb_io_ram_arb.sv
module tb_io_ram_arb;
  import io_ram_pkg::*;

  localparam int AW        = IO_AW;
  localparam int DW        = IO_DW;
  localparam int MAX_BURST = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          ram_en, ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  io_ram_arb_if h_if ();
  io_ram_arb_if e_if ();

  io_ram_arb #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .h        (h_if),
    .e        (e_if),
    .ram_en   (ram_en),
    .ram_wr   (ram_wr),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Power-up contents of the RAM, identical for the RAM stand-in and model.
  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    logic [AW-1:0] t;
    if (a == 12'h010) return 8'h5A;
    t = a ^ (a >> 4) ^ 12'h0C3;
    return t[DW-1:0];
  endfunction

  // RAM stand-in: one synchronous port, 1-cycle read latency.
  logic [DW-1:0] ram_mem [1<<AW];
  bit            ram_vld [1<<AW];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) begin
        ram_mem[ram_addr] <= ram_wdata;
        ram_vld[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= ram_vld[ram_addr] ? ram_mem[ram_addr] : init_val(ram_addr);
      end
    end
  end

  int n_pass = 0, n_fail = 0, n_total = 0;

  // Reference model: who was served last, for how long, whose turn it is.
  logic [DW-1:0] ref_mem [int];
  int            m_ptr, m_last, m_run, m_win;
  bit            m_last_lock;
  logic [AW-1:0] m_addr_hold;
  logic [DW-1:0] m_wdata_hold;
  bit            m_rv [2];
  logic [DW-1:0] m_rv_data [2];
  logic [DW-1:0] m_hold [2];
  logic          s_hg, s_eg;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_last = -1; m_run = 0; m_last_lock = 1'b0;
    m_addr_hold = '0; m_wdata_hold = '0;
    for (int i = 0; i < 2; i++) begin
      m_rv[i] = 1'b0; m_rv_data[i] = '0; m_hold[i] = '0;
    end
  endtask

  // Predict this cycle's winner and compare every DUT output (at negedge).
  task automatic compare();
    bit            hr, er;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    if (!rst_n) model_reset();
    hr = rst_n && h_if.req;
    er = rst_n && e_if.req;
    if (!hr && !er)     m_win = -1;
    else if (hr && !er) m_win = 0;
    else if (er && !hr) m_win = 1;
    else if (m_last >= 0 && m_last_lock && m_run < MAX_BURST) m_win = m_last;
    else                m_win = m_ptr;
    exp_wr = 1'b0; exp_addr = m_addr_hold; exp_wd = m_wdata_hold;
    if (m_win == 0) begin
      exp_wr = h_if.we; exp_addr = h_if.addr; exp_wd = h_if.wdata;
    end else if (m_win == 1) begin
      exp_wr = e_if.we; exp_addr = e_if.addr; exp_wd = e_if.wdata;
    end
    s_hg = h_if.gnt;
    s_eg = e_if.gnt;
    check("h_gnt", 32'(h_if.gnt), 32'(m_win == 0));
    check("e_gnt", 32'(e_if.gnt), 32'(m_win == 1));
    check("ram_en", 32'(ram_en), 32'(m_win >= 0));
    check("ram_wr", 32'(ram_wr), 32'(exp_wr));
    check("ram_addr", 32'(ram_addr), 32'(exp_addr));
    check("ram_wdata", 32'(ram_wdata), 32'(exp_wd));
    check("h_rvalid", 32'(h_if.rvalid), 32'(m_rv[0]));
    check("e_rvalid", 32'(e_if.rvalid), 32'(m_rv[1]));
    check("h_rdata", 32'(h_if.rdata), 32'(m_rv[0] ? m_rv_data[0] : m_hold[0]));
    check("e_rdata", 32'(e_if.rdata), 32'(m_rv[1] ? m_rv_data[1] : m_hold[1]));
  endtask

  // Advance the model across the rising edge using the inputs just sampled.
  task automatic update();
    bit            we, lk;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    if (!rst_n) begin model_reset(); return; end
    for (int i = 0; i < 2; i++) begin
      if (m_rv[i]) m_hold[i] = m_rv_data[i];
      m_rv[i] = 1'b0;
    end
    if (m_win < 0) begin
      m_last = -1; m_run = 0; m_last_lock = 1'b0;
      return;
    end
    if (m_win == 0) begin
      we = h_if.we; a = h_if.addr; wd = h_if.wdata; lk = h_if.lock;
    end else begin
      we = e_if.we; a = e_if.addr; wd = e_if.wdata; lk = e_if.lock;
    end
    m_run = (m_win == m_last) ? ((m_run < MAX_BURST) ? m_run + 1 : MAX_BURST) : 1;
    m_last = m_win; m_last_lock = lk; m_ptr = 1 - m_win;
    m_addr_hold = a; m_wdata_hold = wd;
    if (we) ref_mem[int'(a)] = wd;
    else begin
      m_rv[m_win] = 1'b1;
      m_rv_data[m_win] = ref_read(a);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic drive_h(bit req, bit we, logic [AW-1:0] a, logic [DW-1:0] wd, bit lk);
    h_if.req = req; h_if.we = we; h_if.addr = a; h_if.wdata = wd; h_if.lock = lk;
  endtask

  task automatic drive_e(bit req, bit we, logic [AW-1:0] a, logic [DW-1:0] wd, bit lk);
    e_if.req = req; e_if.we = we; e_if.addr = a; e_if.wdata = wd; e_if.lock = lk;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first_h, h_cnt;
    bit e_at [20];
    model_reset();
    drive_h(0, 0, '0, '0, 0);
    drive_e(0, 0, '0, '0, 0);
    repeat (2) cycle();
    rst_n = 1'b1;

    // Single host read of the preloaded location, then idle hold.
    drive_h(1, 0, 12'h010, 8'h00, 0);
    cycle();
    check("s1_rvalid", 32'(h_if.rvalid), 32'd1);
    check("s1_rdata", 32'(h_if.rdata), 32'h5A);
    drive_h(0, 0, 12'h010, 8'h00, 0);
    repeat (3) cycle();
    check("s1_hold_rvalid", 32'(h_if.rvalid), 32'd0);
    check("s1_hold_rdata", 32'(h_if.rdata), 32'h5A);

    // Both reading continuously after reset: strict alternation from H.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_h(1, 0, AW'($urandom_range(0, 4095)), '0, 0);
      drive_e(1, 0, AW'($urandom_range(0, 4095)), '0, 0);
      cycle();
      check("s2_alt_h", 32'(s_hg), 32'(i % 2 == 0));
    end

    // E locks a write burst while H waits.
    drive_e(0, 0, '0, '0, 0);
    drive_h(1, 0, 12'h123, '0, 0);
    cycle();
    first_h = -1;
    for (int i = 0; i < 20; i++) begin
      drive_h(1, 0, AW'($urandom_range(0, 4095)), '0, 0);
      drive_e(1, 1, 12'h7FF, 8'h33, 1);
      cycle();
      e_at[i] = s_eg;
      if (s_hg && first_h < 0) first_h = i;
    end
    check("s3_e_first", 32'(e_at[0]), 32'd1);
    check("s3_h_slot", 32'(first_h), 32'(MAX_BURST));
    check("s3_e_resume", 32'(e_at[MAX_BURST + 1]), 32'd1);

    // H locked with no competitor, then E arrives.
    drive_e(0, 0, '0, '0, 0);
    h_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      drive_h(1, 0, AW'($urandom_range(0, 4095)), '0, 1);
      cycle();
      if (s_hg) h_cnt++;
    end
    check("s4_h_every_cycle", 32'(h_cnt), 32'd30);
    drive_e(1, 0, 12'h7FF, '0, 0);
    cycle();
    check("s4_e_first_req", 32'(s_eg), 32'd1);

    // H writes, E reads the same address the next cycle.
    drive_h(0, 0, '0, '0, 0);
    drive_e(0, 0, '0, '0, 0);
    cycle();
    drive_h(1, 1, 12'hFFF, 8'hA5, 0);
    cycle();
    drive_h(0, 0, '0, '0, 0);
    drive_e(1, 0, 12'hFFF, '0, 0);
    cycle();
    check("s5_e_rvalid", 32'(e_if.rvalid), 32'd1);
    check("s5_e_rdata", 32'(e_if.rdata), 32'hA5);
    drive_e(0, 0, '0, '0, 0);
    cycle();

    // Reset lands the cycle after a read grant.
    drive_h(1, 0, 12'h010, '0, 0);
    cycle();
    rst_n = 1'b0;
    #1;
    check("s6_rvalid_cleared", 32'(h_if.rvalid), 32'd0);
    check("s6_gnt_in_reset", 32'(h_if.gnt), 32'd0);
    check("s6_ram_en_in_reset", 32'(ram_en), 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    drive_e(1, 0, 12'h020, '0, 0);
    cycle();
    check("s6_first_grant_h", 32'(s_hg), 32'd1);

    // Random traffic over a small address window to force collisions.
    for (int i = 0; i < 400; i++) begin
      drive_h(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              12'hFF0 | AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)),
              $urandom_range(0, 3) != 0);
      drive_e(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              12'hFF0 | AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)),
              $urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
